// File: rtl/mul_issue_ctrl.sv
// Issue/writeback controller for the RV32M multiply path: feeds mul32, tracks in-flight
// ops in a latency-matched shadow pipe and buffers results under credit-based admission.
module mul_issue_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5,
    parameter int MUL_LAT    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    output logic                  mul_valid_in,
    output logic [DATA_WIDTH-1:0] mul_a,
    output logic [DATA_WIDTH-1:0] mul_b,
    output logic                  mul_a_signed,
    output logic                  mul_b_unsigned,
    input  logic [DATA_WIDTH-1:0] mul_r_high,
    input  logic [DATA_WIDTH-1:0] mul_r_low,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic [TAG_WIDTH-1:0]  res_tag,
    output logic                  busy
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(FIFO_DEPTH);

    logic [CNT_W-1:0]      inflight_q, inflight_d, count_q, count_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [MUL_LAT-1:0]    sh_vld_q, sh_vld_d;
    logic [MUL_LAT-1:0]    sh_hi_q;
    logic [TAG_WIDTH-1:0]  sh_tag_q  [MUL_LAT];
    logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic [TAG_WIDTH-1:0]  fifo_tag_q  [FIFO_DEPTH];

    logic                  accept, complete, pop, sel_high;
    logic [CNT_W:0]        used;
    logic [DATA_WIDTH-1:0] push_data;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Buffer slots already promised (in flight) count against admission, so mul32 never overruns the FIFO.
    assign used           = {1'b0, inflight_q} + {1'b0, count_q};
    assign req_ready      = rst_n && !flush && (used < DEPTH_C);
    assign accept         = req_valid && req_ready;
    assign mul_valid_in   = accept;
    assign mul_a          = req_a;
    assign mul_b          = req_b;
    assign mul_a_signed   = (req_op != 2'b11);
    assign mul_b_unsigned = req_op[1];
    assign sel_high       = (req_op != 2'b00);

    // Completion follows the shadow pipe, so stale mul32 outputs after flush/reset are ignored.
    assign complete  = sh_vld_q[MUL_LAT-1] && !flush;
    assign push_data = sh_hi_q[MUL_LAT-1] ? mul_r_high : mul_r_low;
    assign pop       = res_valid && res_ready && !flush;

    assign res_valid = (count_q != '0);
    assign res_data  = fifo_data_q[rd_ptr_q];
    assign res_tag   = fifo_tag_q[rd_ptr_q];
    assign busy      = (inflight_q != '0) || (count_q != '0);

    always_comb begin
        sh_vld_d   = (sh_vld_q << 1) | MUL_LAT'(accept);
        inflight_d = inflight_q;
        count_d    = count_q;
        wr_ptr_d   = complete ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop ? next_ptr(rd_ptr_q) : rd_ptr_q;
        if (accept && !complete) inflight_d = inflight_q + CNT_W'(1);
        if (!accept && complete) inflight_d = inflight_q - CNT_W'(1);
        if (complete && !pop)    count_d    = count_q + CNT_W'(1);
        if (!complete && pop)    count_d    = count_q - CNT_W'(1);
        if (flush) begin
            sh_vld_d   = '0;
            inflight_d = '0;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_vld_q   <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            sh_vld_q   <= sh_vld_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Payload storage carries no reset; the valid bits and count qualify it.
    always_ff @(posedge clk) begin
        sh_hi_q     <= (sh_hi_q << 1) | MUL_LAT'(sel_high);
        sh_tag_q[0] <= req_tag;
        for (int i = 1; i < MUL_LAT; i++) begin
            sh_tag_q[i] <= sh_tag_q[i-1];
        end
        if (complete) begin
            fifo_data_q[wr_ptr_q] <= push_data;
            fifo_tag_q[wr_ptr_q]  <= sh_tag_q[MUL_LAT-1];
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(complete && count_q == FULL_C));
        end
    end
`endif

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl with a behavioural 4-stage mul32 model.
module tb_mul_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic [4:0]  req_tag = 5'd0;
    logic        mul_valid_in;
    logic [31:0] mul_a, mul_b;
    logic        mul_a_signed, mul_b_unsigned;
    logic [31:0] mul_r_high, mul_r_low;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic [4:0]  res_tag;
    logic        busy;

    int n_chk = 0;
    int n_pass = 0;
    int acc = 0;

    mul_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .mul_valid_in(mul_valid_in), .mul_a(mul_a), .mul_b(mul_b),
        .mul_a_signed(mul_a_signed), .mul_b_unsigned(mul_b_unsigned),
        .mul_r_high(mul_r_high), .mul_r_low(mul_r_low),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_tag(res_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    // mul32 stand-in: product of the sampled operands appears four edges later.
    logic [63:0] ea, eb, prod;
    logic [63:0] mp [4];
    always_comb begin
        ea   = mul_a_signed   ? {{32{mul_a[31]}}, mul_a} : {32'd0, mul_a};
        eb   = mul_b_unsigned ? {32'd0, mul_b} : {{32{mul_b[31]}}, mul_b};
        prod = ea * eb;
    end
    always @(posedge clk) begin
        mp[0] <= prod;
        mp[1] <= mp[0];
        mp[2] <= mp[1];
        mp[3] <= mp[2];
    end
    assign mul_r_high = mp[3][63:32];
    assign mul_r_low  = mp[3][31:0];

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", name, obs, exp);
    endtask

    task automatic chkb(input string name, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", name, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [1:0] exp_sgn);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        #1;
        chkb("issue_ready", req_ready, 1'b1);
        chkb("issue_mvi", mul_valid_in, 1'b1);
        chk("issue_sign", {30'd0, mul_a_signed, mul_b_unsigned}, {30'd0, exp_sgn});
        tick();
        req_valid = 1'b0;
    endtask

    // Called in the cycle after accept; expects res_valid to rise exactly in accept+5.
    task automatic wait_result(input logic [31:0] exp_data, input logic [4:0] exp_tag);
        for (int k = 1; k <= 5; k++) begin
            #1;
            chkb("lat_res_valid", res_valid, (k == 5));
            if (k < 5) tick();
        end
        chk("lat_data", res_data, exp_data);
        chk("lat_tag", {27'd0, res_tag}, {27'd0, exp_tag});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, with a request pending
        req_valid = 1'b1;
        req_a = 32'd1;
        req_b = 32'd1;
        #2;
        chkb("rst_req_ready", req_ready, 1'b0);
        chkb("rst_res_valid", res_valid, 1'b0);
        chkb("rst_busy", busy, 1'b0);
        chkb("rst_mvi", mul_valid_in, 1'b0);
        req_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chkb("post_rst_ready", req_ready, 1'b1);

        // MUL 7*6
        res_ready = 1'b1;
        issue(2'b00, 32'd7, 32'd6, 5'd3, 2'b10);
        wait_result(32'h0000_002A, 5'd3);
        chkb("t1_busy_hold", busy, 1'b1);
        tick();
        #1;
        chkb("t1_res_valid_off", res_valid, 1'b0);
        chkb("t1_busy_off", busy, 1'b0);

        // Back-to-back MULH, MULHU, MULHSU
        issue(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd1, 2'b10);
        issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 2'b01);
        issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 2'b11);
        tick();
        tick();
        #1;
        chkb("t2_v0", res_valid, 1'b1);
        chk("t2_mulh", res_data, 32'h4000_0000);
        chk("t2_tag0", {27'd0, res_tag}, 32'd1);
        tick();
        #1;
        chk("t2_mulhu", res_data, 32'hFFFF_FFFE);
        chk("t2_tag1", {27'd0, res_tag}, 32'd2);
        tick();
        #1;
        chk("t2_mulhsu", res_data, 32'hFFFF_FFFF);
        chk("t2_tag2", {27'd0, res_tag}, 32'd3);
        tick();
        #1;
        chkb("t2_drained", res_valid, 1'b0);

        // Credit exhaustion with writeback stalled
        res_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1;
            req_op    = 2'b00;
            req_a     = 32'(i + 1);
            req_b     = 32'd2;
            req_tag   = 5'(8 + i);
            #1;
            if (req_ready) acc++;
            tick();
        end
        req_valid = 1'b0;
        #1;
        chk("t3_accepts", 32'(acc), 32'd4);
        chkb("t3_ready_low", req_ready, 1'b0);
        chkb("t3_res_valid", res_valid, 1'b1);
        chkb("t3_busy", busy, 1'b1);
        res_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1;
            chk("t3_data", res_data, 32'(2 * (j + 1)));
            chk("t3_tag", {27'd0, res_tag}, 32'(8 + j));
            if (j == 0) chkb("t3_ready_pop_cycle", req_ready, 1'b0);
            if (j == 1) chkb("t3_ready_after_pop", req_ready, 1'b1);
            tick();
        end
        #1;
        chkb("t3_drained", res_valid, 1'b0);
        chkb("t3_idle", busy, 1'b0);

        // Flush with two ops in flight and a request in the flush cycle
        issue(2'b00, 32'd2, 32'd2, 5'd20, 2'b10);
        issue(2'b00, 32'd3, 32'd3, 5'd21, 2'b10);
        req_valid = 1'b1;
        req_a     = 32'd4;
        req_b     = 32'd4;
        req_tag   = 5'd22;
        flush     = 1'b1;
        #1;
        chkb("t4_flush_ready", req_ready, 1'b0);
        chkb("t4_flush_mvi", mul_valid_in, 1'b0);
        tick();
        flush     = 1'b0;
        req_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            chkb("t4_no_result", res_valid, 1'b0);
            if (k == 0) chkb("t4_busy_cleared", busy, 1'b0);
            tick();
        end
        issue(2'b00, 32'd3, 32'd5, 5'd7, 2'b10);
        wait_result(32'd15, 5'd7);
        tick();

        // Reset with two in flight and one buffered
        res_ready = 1'b0;
        issue(2'b00, 32'd9, 32'd9, 5'd1, 2'b10);
        tick();
        issue(2'b00, 32'd8, 32'd8, 5'd2, 2'b10);
        issue(2'b00, 32'd7, 32'd7, 5'd3, 2'b10);
        tick();
        #1;
        chkb("t5_buffered", res_valid, 1'b1);
        req_valid = 1'b1;
        rst_n     = 1'b0;
        #1;
        chkb("t5_rst_res_valid", res_valid, 1'b0);
        chkb("t5_rst_busy", busy, 1'b0);
        chkb("t5_rst_mvi", mul_valid_in, 1'b0);
        chkb("t5_rst_ready", req_ready, 1'b0);
        tick();
        rst_n     = 1'b1;
        req_valid = 1'b0;
        res_ready = 1'b1;
        #1;
        chkb("t5_ready_back", req_ready, 1'b1);
        for (int k = 0; k < 8; k++) begin
            #1;
            chkb("t5_no_stale", res_valid, 1'b0);
            tick();
        end

        // Accept and pop in the same cycle with one credit left
        res_ready = 1'b0;
        issue(2'b00, 32'd10, 32'd1, 5'd1, 2'b10);
        issue(2'b00, 32'd11, 32'd1, 5'd2, 2'b10);
        issue(2'b00, 32'd12, 32'd1, 5'd3, 2'b10);
        repeat (4) tick();
        #1;
        chkb("t6_valid", res_valid, 1'b1);
        chkb("t6_one_credit", req_ready, 1'b1);
        chk("t6_head0", res_data, 32'd10);
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_a     = 32'd13;
        req_b     = 32'd1;
        req_tag   = 5'd4;
        res_ready = 1'b1;
        #1;
        chkb("t6_accept_with_pop", mul_valid_in, 1'b1);
        tick();
        req_valid = 1'b0;
        #1;
        chkb("t6_credit_kept", req_ready, 1'b1);
        chk("t6_head1", res_data, 32'd11);
        chk("t6_tag1", {27'd0, res_tag}, 32'd2);
        tick();
        #1;
        chk("t6_head2", res_data, 32'd12);
        chk("t6_tag2", {27'd0, res_tag}, 32'd3);
        tick();
        #1;
        chkb("t6_gap_valid", res_valid, 1'b0);
        chkb("t6_gap_busy", busy, 1'b1);
        tick();
        #1;
        chkb("t6_gap_valid2", res_valid, 1'b0);
        tick();
        #1;
        chkb("t6_last_valid", res_valid, 1'b1);
        chk("t6_last_data", res_data, 32'd13);
        chk("t6_last_tag", {27'd0, res_tag}, 32'd4);
        tick();
        #1;
        chkb("t6_end_valid", res_valid, 1'b0);
        chkb("t6_end_busy", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mul_issue_ctrl.md
Name: mul_issue_ctrl

Overview:
- Issue/writeback controller for the RV32M multiply path, between the execute-stage dispatch and the 4-stage mul32 Booth multiplier.
- Takes MUL/MULH/MULHSU/MULHU requests with a destination tag and drives mul32's operands, signedness and valid.
- Tracks in-flight ops in a shadow pipeline aligned to mul32 latency and selects the high or low result word.
- Buffers results in a FIFO with credit-based admission, because mul32 cannot stall.

Parameters:
DATA_WIDTH, 32, operand/result width
TAG_WIDTH, 5, destination-register tag width
MUL_LAT, 4, mul32 latency in clock edges from valid_input sample to valid_output
FIFO_DEPTH, 4, result buffer entries; must be >= 1

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  pipeline kill; drops all in-flight and buffered ops
req_valid  input  1  request present
req_ready  output  1  request accepted when req_valid && req_ready
req_op  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (funct3[1:0])
req_a  input  DATA_WIDTH  rs1
req_b  input  DATA_WIDTH  rs2
req_tag  input  TAG_WIDTH  rd tag
mul_valid_in  output  1  to mul32 valid_input
mul_a  output  DATA_WIDTH  to mul32 a
mul_b  output  DATA_WIDTH  to mul32 b
mul_a_signed  output  1  to mul32 is_unsigned[1]
mul_b_unsigned  output  1  to mul32 is_unsigned[0]
mul_r_high  input  DATA_WIDTH  from mul32 R_high
mul_r_low  input  DATA_WIDTH  from mul32 R_low
res_valid  output  1  result available
res_ready  input  1  writeback accepts result
res_data  output  DATA_WIDTH  selected result word
res_tag  output  TAG_WIDTH  rd tag of res_data
busy  output  1  any op in flight or buffered

Behaviour:
- Reset (async, rst_n=0): shadow valid bits, FIFO pointers/count and in-flight counter cleared; req_ready=0 during reset, res_valid=0, busy=0, mul_valid_in=0.
- Admission: credits = FIFO_DEPTH - inflight - fifo_count. req_ready = !flush && credits>0. A pop in the same cycle does not free a credit until the next cycle. No combinational path from res_ready to req_ready.
- Issue, combinational: mul_a=req_a, mul_b=req_b, mul_valid_in=req_valid&&req_ready.
- Signedness by op: MUL a_signed=1, b_unsigned=0; MULH 1,0; MULHSU 1,1; MULHU 0,1.
- Shadow pipe: MUL_LAT-stage register of {valid, tag, sel_high}. sel_high=0 for MUL, else 1. Stage 0 loads on accept.
- Completion is driven by the shadow valid at stage MUL_LAT-1, not by mul32 valid_output. A stale mul32 output after flush is ignored.
- On completion, push {tag, sel_high ? mul_r_high : mul_r_low} into the FIFO on the same edge.
- Latency: request accepted in cycle C gives res_valid=1 in cycle C+5 if the FIFO was empty.
- FIFO is circular, with pointers wrapping at FIFO_DEPTH. res_valid = count!=0. res_data/res_tag come from the head and stay stable while res_valid && !res_ready.
- Push and pop in the same cycle leave count unchanged. Push into a full FIFO is impossible by the credit rule; assert on violation.
- inflight: +1 on accept, -1 on completion; a simultaneous accept and completion leave it unchanged.
- Flush (synchronous, dominates):
  - clears all shadow valids, inflight and FIFO count/pointers on the next edge;
  - request in the flush cycle is not accepted;
  - completion in the flush cycle is dropped;
  - res_valid=0 the cycle after flush.
- busy = inflight!=0 || count!=0.
- Back-to-back issue at one per cycle is supported while credits remain.

Test Plan:
- MUL a=7,b=6, res_ready=1 -> res_data=0x0000002A, tag echoed, res_valid exactly 5 cycles after accept, busy low after pop.
- Issue MULH 0x80000000*0x80000000, then MULHU 0xFFFFFFFF*0xFFFFFFFF, then MULHSU a=0xFFFFFFFF,b=0xFFFFFFFF back-to-back -> in order: 0x40000000, 0xFFFFFFFE, 0xFFFFFFFF.
- res_ready=0, req_valid=1 for 8 cycles -> exactly 4 accepts, then req_ready=0. After 4 results buffered, raise res_ready -> 4 results in order, req_ready returns one cycle after the first pop.
- Issue 3 ops, assert flush 2 cycles later -> no res_valid ever for those tags; a new MUL 3*5 issued after flush returns 15 with correct tag.
- Pull rst_n low with 2 ops in flight and 1 buffered -> res_valid, busy and mul_valid_in low immediately. After release, req_ready=1 and no stale result appears.
- Accept a new op in the same cycle a result pops with credits=1 -> no overflow, count/inflight consistent, all results delivered.
